// File: rtl/pwm_ramp_ctrl.sv
// Slew-limited duty/direction sequencer for one PWM motor channel.
// Reversals ramp to zero and hold a dead time before dir flips; estop forces zero duty and brake.
module pwm_ramp_ctrl #(
    parameter int CTR_LEN    = 10,
    parameter int STEP       = 8,
    parameter int TICK_DIV   = 1024,
    parameter int DEAD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CTR_LEN-1:0] cmd_duty,
    input  logic               cmd_dir,
    input  logic               estop,
    output logic [CTR_LEN-1:0] compare,
    output logic               dir,
    output logic               brake,
    output logic               busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [PW-1:0]      TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DEAD_INIT = DW'(DEAD_TICKS);
    localparam logic [CTR_LEN:0]   STEP_W    = (CTR_LEN + 1)'(STEP);
    localparam logic [CTR_LEN-1:0] STEP_C    = CTR_LEN'(STEP);

    typedef enum logic [2:0] {S_HOLD, S_RAMP, S_REV, S_DEAD, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [CTR_LEN-1:0] compare_q, compare_d;
    logic [CTR_LEN-1:0] target_q, target_d;
    logic               dir_q, dir_d;
    logic               pend_dir_q, pend_dir_d;
    logic               brake_q, brake_d;
    logic [DW-1:0]      dead_q, dead_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;

    logic               tick, accept, rev_req, pdir_n;
    logic [CTR_LEN-1:0] tgt_n, stepped;

    // Difference taken one bit wider so the clip test never sees a wrapped value.
    function automatic logic [CTR_LEN-1:0] step_to(input logic [CTR_LEN-1:0] c,
                                                   input logic [CTR_LEN-1:0] t);
        logic [CTR_LEN:0] diff;
        if (t >= c) begin
            diff = {1'b0, t} - {1'b0, c};
            return (diff <= STEP_W) ? t : c + STEP_C;
        end
        diff = {1'b0, c} - {1'b0, t};
        return (diff <= STEP_W) ? t : c - STEP_C;
    endfunction

    assign tick      = (pcnt_q == TICK_LAST);
    assign cmd_ready = rst & ~estop & (state_q != S_STOP);
    assign accept    = cmd_valid & cmd_ready;
    assign tgt_n     = accept ? cmd_duty : target_q;
    assign pdir_n    = accept ? cmd_dir : pend_dir_q;
    assign rev_req   = accept & (cmd_dir != dir_q);

    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
        state_d    = state_q;
        target_d   = tgt_n;
        pend_dir_d = pdir_n;
        dir_d      = dir_q;
        dead_d     = dead_q;
        // The step always uses the target held before this cycle's accept.
        stepped    = (tick && (state_q == S_RAMP || state_q == S_REV))
                   ? step_to(compare_q, (state_q == S_REV) ? '0 : target_q) : compare_q;
        compare_d  = stepped;

        if (estop) begin
            state_d    = S_STOP;
            compare_d  = '0;
            target_d   = '0;
            pend_dir_d = dir_q;
        end else begin
            case (state_q)
                S_HOLD, S_RAMP: begin
                    if (rev_req) begin
                        if (stepped == '0) begin
                            state_d = S_DEAD;
                            dead_d  = DEAD_INIT;
                        end else begin
                            state_d = S_REV;
                        end
                    end else begin
                        state_d = (stepped == tgt_n) ? S_HOLD : S_RAMP;
                    end
                end
                S_REV: begin
                    if (accept && !rev_req) begin
                        state_d = (stepped == tgt_n) ? S_HOLD : S_RAMP;
                    end else if (stepped == '0) begin
                        state_d = S_DEAD;
                        dead_d  = DEAD_INIT;
                    end
                end
                S_DEAD: begin
                    if (tick) begin
                        dead_d = dead_q - 1'b1;
                        if (dead_q <= 1) begin
                            dir_d   = pdir_n;
                            state_d = (tgt_n == '0) ? S_HOLD : S_RAMP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) state_d = S_HOLD;
                end
                default: state_d = S_HOLD;
            endcase
        end
        brake_d = (state_d == S_STOP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HOLD;
            compare_q  <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
            pend_dir_q <= 1'b0;
            brake_q    <= 1'b0;
            dead_q     <= '0;
            pcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            compare_q  <= compare_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            brake_q    <= brake_d;
            dead_q     <= dead_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign compare = compare_q;
    assign dir     = dir_q;
    assign brake   = brake_q;
    assign busy    = (state_q == S_RAMP) | (state_q == S_REV) | (state_q == S_DEAD);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: flag-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed compare/dir sequences.
module tb_pwm_ramp_ctrl;
    localparam int CTR_LEN    = 10;
    localparam int STEP       = 8;
    localparam int TICK_DIV   = 4;
    localparam int DEAD_TICKS = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_dir = 1'b0;
    logic               estop = 1'b0;
    logic [CTR_LEN-1:0] cmd_duty = '0;
    logic               cmd_ready, dir, brake, busy;
    logic [CTR_LEN-1:0] compare;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.CTR_LEN(CTR_LEN), .STEP(STEP), .TICK_DIV(TICK_DIV), .DEAD_TICKS(DEAD_TICKS)) dut (
        .clk(clk), .rst(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .estop(estop),
        .compare(compare), .dir(dir), .brake(brake), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: busy is "reversing, in dead time, or compare still off target".
    int m_cmp, m_tgt, m_dead, m_edges;
    bit m_dir, m_pdir, m_rev, m_stop, m_brake, m_last_tick;

    function automatic int step_toward(input int c, input int t);
        if (t > c) return (t - c <= STEP) ? t : c + STEP;
        return (c - t <= STEP) ? t : c - STEP;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit tk, acc;
        int ncmp;
        if (!rst_n) begin
            m_cmp = 0; m_tgt = 0; m_dead = 0; m_edges = 0;
            m_dir = 0; m_pdir = 0; m_rev = 0; m_stop = 0; m_brake = 0; m_last_tick = 0;
        end else begin
            tk = (m_edges % TICK_DIV) == TICK_DIV - 1;
            m_edges++;
            m_last_tick = tk;
            acc = cmd_valid && !estop && !m_stop;
            if (estop) begin
                m_stop = 1; m_brake = 1; m_cmp = 0; m_tgt = 0;
                m_rev = 0; m_dead = 0; m_pdir = m_dir;
            end else if (m_stop) begin
                if (tk) begin m_stop = 0; m_brake = 0; end
            end else begin
                ncmp = m_cmp;
                if (tk && m_dead == 0) ncmp = step_toward(m_cmp, m_rev ? 0 : m_tgt);
                if (acc) begin m_tgt = int'(cmd_duty); m_pdir = cmd_dir; end
                if (m_dead > 0) begin
                    if (tk) begin
                        m_dead--;
                        if (m_dead == 0) m_dir = m_pdir;
                    end
                end else if (m_rev) begin
                    if (acc && cmd_dir == m_dir) m_rev = 0;
                    else if (ncmp == 0) begin m_rev = 0; m_dead = DEAD_TICKS; end
                end else if (acc && cmd_dir != m_dir) begin
                    if (ncmp == 0) m_dead = DEAD_TICKS;
                    else m_rev = 1;
                end
                m_cmp = ncmp;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_compare", 32'(compare), m_cmp);
            chk("model_dir", 32'(dir), 32'(m_dir));
            chk("model_brake", 32'(brake), 32'(m_brake));
            chk("model_busy", 32'(busy), 32'(!m_stop && (m_rev || m_dead > 0 || m_cmp != m_tgt)));
            chk("model_ready", 32'(cmd_ready), 32'(!estop && !m_stop));
        end
    end

    task automatic send(input int duty, input bit d);
        cmd_valid = 1'b1;
        cmd_duty  = CTR_LEN'(duty);
        cmd_dir   = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic next_tick();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_last_tick && n < 3 * TICK_DIV);
        if (!m_last_tick) begin
            checks++; errors++;
            $display("FAIL tick_wait: no tick within %0d cycles", n);
        end
    endtask

    task automatic expect_tick(input string name, input int v);
        next_tick();
        chk(name, 32'(compare), v);
    endtask

    task automatic wait_cmp(input int v, input int max_ticks);
        for (int i = 0; i < max_ticks && int'(compare) != v; i++) next_tick();
        chk("reach_target", 32'(compare), v);
    endtask

    int seq_a[5]   = '{8, 16, 24, 32, 40};
    int seq_c[4]   = '{37, 29, 21, 20};
    int seq_d[7]   = '{12, 4, 0, 0, 0, 8, 16};
    bit dir_d[7]   = '{0, 0, 0, 0, 1, 1, 1};
    int seq_e1[4]  = '{8, 16, 24, 32};
    int seq_e2[3]  = '{24, 16, 10};

    initial begin
        #2;
        chk("rst_compare", 32'(compare), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_brake", 32'(brake), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        #10 rst_n = 1'b1;
        next_tick();

        // ramp 0 -> 40
        send(40, 0);
        for (int i = 0; i < 5; i++) begin
            expect_tick("ramp_up", seq_a[i]);
            chk("ramp_busy", 32'(busy), (i < 4) ? 1 : 0);
        end

        // clipped step and ramp down
        send(45, 0);
        expect_tick("clip_up", 45);
        chk("clip_busy", 32'(busy), 0);
        send(20, 0);
        for (int i = 0; i < 4; i++) expect_tick("ramp_down", seq_c[i]);

        // reversal with dead time
        send(16, 1);
        for (int i = 0; i < 7; i++) begin
            expect_tick("rev_compare", seq_d[i]);
            chk("rev_dir", 32'(dir), 32'(dir_d[i]));
        end
        chk("rev_busy", 32'(busy), 0);

        // back to dir 0 at zero duty
        send(0, 0);
        repeat (4) next_tick();
        chk("back_compare", 32'(compare), 0);
        chk("back_dir", 32'(dir), 0);
        chk("back_busy", 32'(busy), 0);

        // retarget mid ramp
        send(100, 0);
        for (int i = 0; i < 4; i++) expect_tick("retgt_up", seq_e1[i]);
        send(10, 0);
        for (int i = 0; i < 3; i++) expect_tick("retgt_down", seq_e2[i]);
        chk("retgt_busy", 32'(busy), 0);

        // accept on a tick cycle: steps toward old target 50, then to new target 30
        send(50, 0);
        expect_tick("tickacc_up", 18);
        expect_tick("tickacc_up", 26);
        repeat (3) @(posedge clk);
        #1;
        send(30, 0);
        chk("tickacc_step", 32'(compare), 34);
        chk("tickacc_busy", 32'(busy), 1);
        expect_tick("tickacc_final", 30);
        chk("tickacc_hold", 32'(busy), 0);

        // emergency stop
        send(24, 0);
        expect_tick("pre_estop", 24);
        estop = 1'b1;
        #1;
        chk("estop_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_duty  = CTR_LEN'(100);
        @(posedge clk); #1;
        chk("estop_compare", 32'(compare), 0);
        chk("estop_brake", 32'(brake), 1);
        chk("estop_busy", 32'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        estop = 1'b0;
        cmd_valid = 1'b0;
        next_tick();
        chk("release_brake", 32'(brake), 0);
        chk("release_compare", 32'(compare), 0);
        chk("release_ready", 32'(cmd_ready), 1);
        expect_tick("release_stay0", 0);

        // async reset mid-cycle, prescaler restarts
        send(500, 0);
        wait_cmp(500, 80);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_compare", 32'(compare), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(cmd_ready), 0);
        chk("arst_brake", 32'(brake), 0);
        #3;
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_duty  = CTR_LEN'(16);
        cmd_dir   = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("presc_no_tick", 32'(compare), 0);
        @(posedge clk); #1;
        chk("presc_first_tick", 32'(compare), 8);
        expect_tick("presc_second", 16);
        chk("presc_busy", 32'(busy), 0);

        // saturating top end
        send(1020, 0);
        wait_cmp(1020, 140);
        send(1023, 0);
        expect_tick("sat_top", 1023);
        expect_tick("sat_nowrap", 1023);
        chk("sat_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
